// File: rtl/jb_clk_en_sched.sv
// Multi-channel clock-enable scheduler: one frame counter decoded into NUM_CH
// enables at clk/2^sel with a phase offset; config changes land on frame boundaries.
module jb_clk_en_sched #(
    parameter int unsigned NUM_CH       = 4,
    parameter int unsigned MAX_DIV_LOG2 = 4,
    localparam int unsigned CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int unsigned SEL_W       = $clog2(MAX_DIV_LOG2 + 1)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [CH_W-1:0]         cfg_ch,
    input  logic [SEL_W-1:0]        cfg_div_sel,
    input  logic [MAX_DIV_LOG2-1:0] cfg_phase,
    output logic                    cfg_done,
    output logic                    cfg_err,
    output logic [NUM_CH-1:0]       clk_en,
    output logic                    frame_start
);

    localparam int unsigned      CNT_W    = MAX_DIV_LOG2;
    localparam logic [CNT_W-1:0] CNT_LAST = '1;
    localparam logic [CH_W:0]    NUM_CH_L = (CH_W + 1)'(NUM_CH);
    localparam logic [SEL_W-1:0] MAX_SEL  = SEL_W'(MAX_DIV_LOG2);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PEND,
        ST_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [CNT_W-1:0]  cnt_q;
    logic [SEL_W-1:0]  sel_q   [NUM_CH];
    logic [CNT_W-1:0]  phase_q [NUM_CH];

    logic [CH_W-1:0]   sh_ch_q;
    logic [SEL_W-1:0]  sh_sel_q;
    logic [CNT_W-1:0]  sh_phase_q;

    logic              bad_c;
    logic              latch_c;
    logic              apply_c;
    logic              done_d;
    logic              err_d;
    logic [CNT_W-1:0]  mask_c  [NUM_CH];
    logic [NUM_CH-1:0] clk_en_d;

    assign bad_c = ({1'b0, cfg_ch} >= NUM_CH_L) || (cfg_div_sel > MAX_SEL);

    // Next-state and config handshake decode
    always_comb begin
        state_d = state_q;
        latch_c = 1'b0;
        apply_c = 1'b0;
        done_d  = 1'b0;
        err_d   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_valid && cfg_ready) begin
                    if (bad_c) begin
                        err_d = 1'b1;
                    end else begin
                        latch_c = 1'b1;
                        state_d = ST_PEND;
                    end
                end
            end
            ST_PEND: begin
                // Last slot of the frame, or counter idle: swap in before the next slot 0
                if (!enable || (cnt_q == CNT_LAST)) begin
                    apply_c = 1'b1;
                    done_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Per-channel slot match: low sel bits of cnt against low sel bits of phase
    always_comb begin
        clk_en_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            mask_c[i] = '0;
            for (int b = 0; b < CNT_W; b++) begin
                mask_c[i][b] = (SEL_W'(b) < sel_q[i]);
            end
            clk_en_d[i] = enable && ((cnt_q & mask_c[i]) == (phase_q[i] & mask_c[i]));
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Counter, registered outputs, shadow and active config
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q       <= '0;
            clk_en      <= '0;
            frame_start <= 1'b0;
            cfg_ready   <= 1'b1;
            cfg_done    <= 1'b0;
            cfg_err     <= 1'b0;
            sh_ch_q     <= '0;
            sh_sel_q    <= '0;
            sh_phase_q  <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
                sel_q[i]   <= '0;
                phase_q[i] <= '0;
            end
        end else begin
            cnt_q       <= enable ? cnt_q + CNT_W'(1) : '0;
            clk_en      <= clk_en_d;
            frame_start <= enable && (cnt_q == '0);
            cfg_ready   <= (state_d == ST_IDLE);
            cfg_done    <= done_d;
            cfg_err     <= err_d;
            if (latch_c) begin
                sh_ch_q    <= cfg_ch;
                sh_sel_q   <= cfg_div_sel;
                sh_phase_q <= cfg_phase;
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (apply_c && (sh_ch_q == CH_W'(i))) begin
                    sel_q[i]   <= sh_sel_q;
                    phase_q[i] <= sh_phase_q;
                end
            end
        end
    end

endmodule

// File: tb/tb_jb_clk_en_sched.sv
// Self-checking bench for jb_clk_en_sched: scoreboard of per-cycle expected outputs
// plus directed scenario tasks.
module tb_jb_clk_en_sched;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       enable;
    logic       cfg_valid;
    logic [1:0] cfg_ch;
    logic [2:0] cfg_div_sel;
    logic [3:0] cfg_phase;
    logic       cfg_ready;
    logic       cfg_done;
    logic       cfg_err;
    logic [3:0] clk_en;
    logic       frame_start;

    // Second instance with a non-power-of-two channel count for out-of-range channel requests
    logic       c3_enable;
    logic       c3_valid;
    logic [1:0] c3_ch;
    logic [1:0] c3_sel;
    logic [1:0] c3_phase;
    logic       c3_ready;
    logic       c3_done;
    logic       c3_err;
    logic [2:0] c3_clk_en;
    logic       c3_fs;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] clk_en;
        logic       fs;
        logic       ready;
        logic       done;
        logic       err;
    } exp_t;

    exp_t exp_q[$];

    int m_cnt;
    int m_state;
    int m_sel[4];
    int m_phase[4];
    int sh_ch, sh_sel, sh_phase;

    always #5 clk = ~clk;

    jb_clk_en_sched #(.NUM_CH(4), .MAX_DIV_LOG2(4)) u_dut (
        .clk(clk), .reset_n(reset_n), .enable(enable),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_ch(cfg_ch),
        .cfg_div_sel(cfg_div_sel), .cfg_phase(cfg_phase),
        .cfg_done(cfg_done), .cfg_err(cfg_err),
        .clk_en(clk_en), .frame_start(frame_start)
    );

    jb_clk_en_sched #(.NUM_CH(3), .MAX_DIV_LOG2(2)) u_dut3 (
        .clk(clk), .reset_n(reset_n), .enable(c3_enable),
        .cfg_valid(c3_valid), .cfg_ready(c3_ready), .cfg_ch(c3_ch),
        .cfg_div_sel(c3_sel), .cfg_phase(c3_phase),
        .cfg_done(c3_done), .cfg_err(c3_err),
        .clk_en(c3_clk_en), .frame_start(c3_fs)
    );

    // Predict the outputs of the coming posedge from the inputs it will sample
    always @(negedge clk) begin
        exp_t e;
        int   nst;
        int   mask;
        #1;
        e = '0;
        if (!reset_n) begin
            m_cnt   = 0;
            m_state = 0;
            for (int i = 0; i < 4; i++) begin
                m_sel[i]   = 0;
                m_phase[i] = 0;
            end
            e.ready = 1'b1;
        end else begin
            for (int i = 0; i < 4; i++) begin
                mask = (1 << m_sel[i]) - 1;
                e.clk_en[i] = enable && ((m_cnt & mask) == (m_phase[i] & mask));
            end
            e.fs = enable && (m_cnt == 0);
            nst = m_state;
            if (m_state == 0) begin
                if (cfg_valid) begin
                    if (cfg_div_sel > 3'd4) begin
                        e.err = 1'b1;
                    end else begin
                        sh_ch = int'(cfg_ch); sh_sel = int'(cfg_div_sel); sh_phase = int'(cfg_phase);
                        nst = 1;
                    end
                end
            end else if (m_state == 1) begin
                if (!enable || m_cnt == 15) begin
                    m_sel[sh_ch]   = sh_sel;
                    m_phase[sh_ch] = sh_phase;
                    e.done = 1'b1;
                    nst = 2;
                end
            end else begin
                nst = 0;
            end
            e.ready = (nst == 0);
            m_state = nst;
            m_cnt   = enable ? (m_cnt + 1) % 16 : 0;
        end
        exp_q.push_back(e);
    end

    // Compare DUT outputs against the scoreboard just after each posedge
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_tests++;
            if (clk_en !== e.clk_en) begin n_fail++; $display("FAIL sb_clk_en t=%0t got %b want %b", $time, clk_en, e.clk_en); end
            n_tests++;
            if (frame_start !== e.fs) begin n_fail++; $display("FAIL sb_frame_start t=%0t got %b want %b", $time, frame_start, e.fs); end
            n_tests++;
            if (cfg_ready !== e.ready) begin n_fail++; $display("FAIL sb_cfg_ready t=%0t got %b want %b", $time, cfg_ready, e.ready); end
            n_tests++;
            if (cfg_done !== e.done) begin n_fail++; $display("FAIL sb_cfg_done t=%0t got %b want %b", $time, cfg_done, e.done); end
            n_tests++;
            if (cfg_err !== e.err) begin n_fail++; $display("FAIL sb_cfg_err t=%0t got %b want %b", $time, cfg_err, e.err); end
        end
    end

    task automatic wait_cnt(input int v, input string name);
        bit hit = 0;
        for (int k = 0; k < 40 && !hit; k++) begin
            @(negedge clk);
            if (m_cnt == v) hit = 1;
        end
        n_tests++;
        if (!hit) begin n_fail++; $display("FAIL %s_wait_cnt got timeout want cnt=%0d", name, v); end
    endtask

    task automatic test_reset;
        bit ones_ok = 1;
        bit quiet = 1;
        int fs_cnt = 0;
        logic first_fs = 1'b0;
        reset_n = 1'b0; enable = 1'b0; cfg_valid = 1'b0;
        cfg_ch = '0; cfg_div_sel = '0; cfg_phase = '0;
        c3_enable = 1'b0; c3_valid = 1'b0; c3_ch = '0; c3_sel = '0; c3_phase = '0;
        repeat (3) @(negedge clk);
        n_tests++;
        if ({clk_en, frame_start, cfg_done, cfg_err} !== 7'b0) begin
            n_fail++; $display("FAIL reset_outputs got %b want 0000000", {clk_en, frame_start, cfg_done, cfg_err});
        end
        n_tests++;
        if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cfg_ready); end
        reset_n = 1'b1;
        enable  = 1'b1;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            if (clk_en !== 4'hf) ones_ok = 0;
            if (frame_start === 1'b1) fs_cnt++;
            if (c == 0) first_fs = frame_start;
            if (cfg_done !== 1'b0 || cfg_err !== 1'b0 || cfg_ready !== 1'b1) quiet = 0;
        end
        n_tests++;
        if (!ones_ok) begin n_fail++; $display("FAIL reset_div1 got non-1111 clk_en want 1111 every cycle"); end
        n_tests++;
        if (fs_cnt != 2) begin n_fail++; $display("FAIL reset_fs_count got %0d want 2", fs_cnt); end
        n_tests++;
        if (first_fs !== 1'b1) begin n_fail++; $display("FAIL reset_first_fs got %b want 1", first_fs); end
        n_tests++;
        if (!quiet) begin n_fail++; $display("FAIL reset_cfg_quiet got activity want ready=1 done=0 err=0"); end
    endtask

    task automatic test_cfg_rate;
        bit found = 0;
        bit pat_ok = 1;
        int done_cnt = -1;
        int prev;
        logic [3:0] want;
        wait_cnt(5, "cfg_rate");
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div_sel = 3'd2; cfg_phase = 4'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        n_tests++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL cfg_rate_ready_drop got %b want 0", cfg_ready); end
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge clk);
            if (cfg_done === 1'b1) begin found = 1; done_cnt = m_cnt; end
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL cfg_rate_done got none want pulse"); end
        n_tests++;
        if (done_cnt != 0) begin n_fail++; $display("FAIL cfg_rate_done_slot got cnt=%0d want cnt=0", done_cnt); end
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            if (c == 0) begin
                n_tests++;
                if (cfg_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_rate_ready_back got %b want 1", cfg_ready); end
            end
            prev = (m_cnt + 15) % 16;
            want = 4'b1101 | {2'b00, ((prev % 4) == 1), 1'b0};
            if (clk_en !== want) pat_ok = 0;
        end
        n_tests++;
        if (!pat_ok) begin n_fail++; $display("FAIL cfg_rate_pattern got deviation want ch1 at cnt 1,5,9,13 only"); end
    endtask

    task automatic test_cfg_err;
        logic [1:0] chs  [2] = '{2'd3, 2'd0};
        logic [2:0] sels [2] = '{3'd5, 3'd7};
        for (int r = 0; r < 2; r++) begin
            cfg_valid = 1'b1; cfg_ch = chs[r]; cfg_div_sel = sels[r]; cfg_phase = 4'd0;
            @(negedge clk);
            cfg_valid = 1'b0;
            n_tests++;
            if ({cfg_err, cfg_ready} !== 2'b11) begin n_fail++; $display("FAIL cfg_err_pulse sel=%0d got err,ready=%b want 11", sels[r], {cfg_err, cfg_ready}); end
            @(negedge clk);
            n_tests++;
            if (cfg_err !== 1'b0) begin n_fail++; $display("FAIL cfg_err_width sel=%0d got %b want 0", sels[r], cfg_err); end
        end
        c3_valid = 1'b1; c3_ch = 2'd3; c3_sel = 2'd1; c3_phase = 2'd0;
        @(negedge clk);
        c3_valid = 1'b0;
        n_tests++;
        if ({c3_err, c3_ready} !== 2'b11) begin n_fail++; $display("FAIL cfg_err_ch_range got err,ready=%b want 11", {c3_err, c3_ready}); end
        c3_valid = 1'b1; c3_ch = 2'd0; c3_sel = 2'd3;
        @(negedge clk);
        c3_valid = 1'b0;
        n_tests++;
        if ({c3_err, c3_ready} !== 2'b11) begin n_fail++; $display("FAIL cfg_err_sel_range got err,ready=%b want 11", {c3_err, c3_ready}); end
        c3_valid = 1'b1; c3_ch = 2'd2; c3_sel = 2'd2; c3_phase = 2'd1;
        @(negedge clk);
        c3_valid = 1'b0;
        n_tests++;
        if ({c3_err, c3_ready} !== 2'b00) begin n_fail++; $display("FAIL cfg_err_good_accept got err,ready=%b want 00", {c3_err, c3_ready}); end
        @(negedge clk);
        n_tests++;
        if ({c3_done, c3_clk_en, c3_fs} !== 5'b10000) begin n_fail++; $display("FAIL cfg_err_good_done got %b want 10000", {c3_done, c3_clk_en, c3_fs}); end
    endtask

    task automatic test_enable_drop;
        bit off_ok = 1;
        wait_cnt(2, "en_drop");
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div_sel = 3'd3; cfg_phase = 4'd2;
        @(negedge clk);
        cfg_valid = 1'b0;
        wait_cnt(7, "en_drop");
        enable = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({clk_en, frame_start} !== 5'b0) begin n_fail++; $display("FAIL en_drop_outputs got %b want 00000", {clk_en, frame_start}); end
        n_tests++;
        if (cfg_done !== 1'b1) begin n_fail++; $display("FAIL en_drop_done got %b want 1", cfg_done); end
        repeat (3) begin
            @(negedge clk);
            if ({clk_en, frame_start} !== 5'b0) off_ok = 0;
        end
        n_tests++;
        if (!off_ok) begin n_fail++; $display("FAIL en_drop_idle got activity want all enables low"); end
        enable = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({clk_en, frame_start} !== 5'b10011) begin n_fail++; $display("FAIL en_rise_slot0 got %b want 10011", {clk_en, frame_start}); end
        @(negedge clk);
        n_tests++;
        if (clk_en !== 4'b1011) begin n_fail++; $display("FAIL en_rise_slot1 got %b want 1011", clk_en); end
    endtask

    task automatic test_back_to_back;
        bit found1 = 0;
        bit found2 = 0;
        int cyc = 0;
        int t1 = 0, t2 = 0;
        int c1 = -1, c2 = -1;
        wait_cnt(10, "b2b");
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div_sel = 3'd1; cfg_phase = 4'd1;
        for (int k = 0; k < 40 && !found1; k++) begin
            @(negedge clk); cyc++;
            if (cfg_done === 1'b1) begin found1 = 1; t1 = cyc; c1 = m_cnt; end
        end
        cfg_ch = 2'd2; cfg_div_sel = 3'd2; cfg_phase = 4'd3;
        n_tests++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL b2b_ready_in_done got %b want 0", cfg_ready); end
        for (int k = 0; k < 40 && !found2; k++) begin
            @(negedge clk); cyc++;
            if (cfg_done === 1'b1) begin found2 = 1; t2 = cyc; c2 = m_cnt; end
        end
        cfg_valid = 1'b0;
        n_tests++;
        if (!(found1 && found2)) begin n_fail++; $display("FAIL b2b_done got %0d%0d want 11", found1, found2); end
        n_tests++;
        if (t2 - t1 != 16) begin n_fail++; $display("FAIL b2b_gap got %0d want 16", t2 - t1); end
        n_tests++;
        if (c1 != 0 || c2 != 0) begin n_fail++; $display("FAIL b2b_boundary got cnt %0d,%0d want 0,0", c1, c2); end
    endtask

    task automatic test_reset_pend;
        bit ones_ok = 1;
        bit no_done = 1;
        wait_cnt(3, "rst_pend");
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div_sel = 3'd4; cfg_phase = 4'd5;
        @(negedge clk);
        cfg_valid = 1'b0;
        @(negedge clk);
        n_tests++;
        if (cfg_ready !== 1'b0) begin n_fail++; $display("FAIL rst_pend_pending got ready=%b want 0", cfg_ready); end
        @(posedge clk);
        #3;
        reset_n = 1'b0;
        #1;
        n_tests++;
        if ({clk_en, frame_start, cfg_done, cfg_err, cfg_ready} !== 8'b00000001) begin
            n_fail++; $display("FAIL rst_pend_async got %b want 00000001", {clk_en, frame_start, cfg_done, cfg_err, cfg_ready});
        end
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (clk_en !== 4'hf) ones_ok = 0;
            if (cfg_done !== 1'b0) no_done = 0;
        end
        n_tests++;
        if (!no_done) begin n_fail++; $display("FAIL rst_pend_no_done got pulse want none"); end
        n_tests++;
        if (!ones_ok) begin n_fail++; $display("FAIL rst_pend_div1 got non-1111 clk_en want 1111"); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_cfg_rate();
        test_cfg_err();
        test_enable_drop();
        test_back_to_back();
        test_reset_pend();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
